// File: rtl/pipe_pkg.sv
// Shared types and CPU control-field layout for the inter-stage pipeline registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  localparam int RESULTSRC_W = 2;
  localparam int ALUCTRL_W   = 4;
  localparam int FUNCT3_W    = 3;
  localparam int CTRL_W_CPU  = 15;

  // Bit positions of each control field inside the packed control word (LSB first).
  localparam int FUNCT3_LSB    = 0;
  localparam int MEMREAD_BIT   = FUNCT3_LSB + FUNCT3_W;
  localparam int ALUCTRL_LSB   = MEMREAD_BIT + 1;
  localparam int BRANCH_BIT    = ALUCTRL_LSB + ALUCTRL_W;
  localparam int JUMP_BIT      = BRANCH_BIT + 1;
  localparam int REGWRITE_BIT  = JUMP_BIT + 1;
  localparam int ALUSRC_BIT    = REGWRITE_BIT + 1;
  localparam int MEMWRITE_BIT  = ALUSRC_BIT + 1;
  localparam int RESULTSRC_LSB = MEMWRITE_BIT + 1;

  typedef struct packed {
    logic [RESULTSRC_W-1:0] result_src;
    logic                   mem_write;
    logic                   alu_src;
    logic                   reg_write;
    logic                   jump;
    logic                   branch;
    logic [ALUCTRL_W-1:0]   alu_control;
    logic                   mem_read;
    logic [FUNCT3_W-1:0]    funct3;
  } cpu_ctrl_t;

  function automatic logic [CTRL_W_CPU-1:0] pack_ctrl(input cpu_ctrl_t c);
    return c;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; adds 0..3 per enabled cycle.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic [1:0]   amount,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W:0] sum;

  // The carry-out bit flags that the sum passed 2^W-1.
  always_comb begin
    sum = {1'b0, count} + (W+1)'(amount);
  end

  // NOTE: sequential state is updated with <= only so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= sum[W] ? '1 : sum[W-1:0];
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, optional 2-entry skid,
// synchronous flush and saturating stall/squash counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W  = 175,
  parameter int CTRL_W  = CTRL_W_CPU,
  parameter int SKID_EN = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  squash_cnt
);

  state_t            state, next_state;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic              in_ready_q;
  logic              accept, consume;
  logic              load_main, main_from_skid, load_skid;
  logic              clr_main_ctrl, clr_skid_ctrl;
  logic [1:0]        squash_amt;

  assign out_valid = (state != ST_EMPTY);
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl;

  // in_ready_q doubles as the "out of reset" flag for the combinational variant.
  assign in_ready = (SKID_EN != 0) ? in_ready_q
                                   : (in_ready_q & (!out_valid | out_ready));

  assign accept  = in_valid & in_ready & !flush;
  assign consume = out_valid & out_ready;

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    next_state     = state;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    clr_main_ctrl  = 1'b0;
    clr_skid_ctrl  = 1'b0;
    squash_amt     = 2'd0;
    if (flush) begin
      next_state    = ST_EMPTY;
      clr_main_ctrl = 1'b1;
      clr_skid_ctrl = 1'b1;
      // A beat consumed on the flush cycle was delivered, not squashed.
      case (state)
        ST_FULL: squash_amt = consume ? 2'd0 : 2'd1;
        ST_SKID: squash_amt = consume ? 2'd1 : 2'd2;
        default: squash_amt = 2'd0;
      endcase
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            next_state = ST_FULL;
            load_main  = 1'b1;
          end
        end
        ST_FULL: begin
          if (consume && accept) begin
            load_main = 1'b1;
          end else if (consume) begin
            next_state    = ST_EMPTY;
            clr_main_ctrl = 1'b1;
          end else if (accept && (SKID_EN != 0)) begin
            next_state = ST_SKID;
            load_skid  = 1'b1;
          end
        end
        ST_SKID: begin
          if (consume) begin
            next_state     = ST_FULL;
            load_main      = 1'b1;
            main_from_skid = 1'b1;
            clr_skid_ctrl  = 1'b1;
          end
        end
        default: next_state = ST_EMPTY;
      endcase
    end
  end

  // NOTE: payload registers are reset too, since out_data must read zero out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b0;
      main_data  <= '0;
      main_ctrl  <= '0;
      skid_data  <= '0;
      skid_ctrl  <= '0;
    end else begin
      state      <= next_state;
      in_ready_q <= (next_state != ST_SKID);
      if (load_main) begin
        main_data <= main_from_skid ? skid_data : in_data;
        main_ctrl <= main_from_skid ? skid_ctrl : in_ctrl;
      end else if (clr_main_ctrl) begin
        main_ctrl <= '0;
      end
      if (load_skid) begin
        skid_data <= in_data;
        skid_ctrl <= in_ctrl;
      end else if (clr_skid_ctrl) begin
        skid_ctrl <= '0;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk    (clk),
    .reset  (reset),
    .inc    (out_valid & !out_ready & !flush),
    .amount (2'd1),
    .clr    (cnt_clr),
    .count  (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_squash_cnt (
    .clk    (clk),
    .reset  (reset),
    .inc    (flush),
    .amount (squash_amt),
    .clr    (cnt_clr),
    .count  (squash_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: a skid instance with 4-bit counters and a non-skid instance.
module tb_pipe_stage_reg;

  localparam int DW = 175;
  localparam int CW = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Skid-buffer instance, CNT_W = 4 so saturation is reachable.
  logic          in_valid, in_ready, flush, out_valid, out_ready, cnt_clr;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;
  logic [3:0]    stall_cnt, squash_cnt;

  // Single-register instance.
  logic          n_in_valid, n_in_ready, n_flush, n_out_valid, n_out_ready, n_cnt_clr;
  logic [CW-1:0] n_in_ctrl, n_out_ctrl;
  logic [DW-1:0] n_in_data, n_out_data;
  logic [15:0]   n_stall_cnt, n_squash_cnt;

  int checks   = 0;
  int failures = 0;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1), .CNT_W(4)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ctrl    (in_ctrl),
    .in_data    (in_data),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ctrl   (out_ctrl),
    .out_data   (out_data),
    .cnt_clr    (cnt_clr),
    .stall_cnt  (stall_cnt),
    .squash_cnt (squash_cnt)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(0), .CNT_W(16)) u_dut_ns (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (n_in_valid),
    .in_ready   (n_in_ready),
    .in_ctrl    (n_in_ctrl),
    .in_data    (n_in_data),
    .flush      (n_flush),
    .out_valid  (n_out_valid),
    .out_ready  (n_out_ready),
    .out_ctrl   (n_out_ctrl),
    .out_data   (n_out_data),
    .cnt_clr    (n_cnt_clr),
    .stall_cnt  (n_stall_cnt),
    .squash_cnt (n_squash_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic v, input logic [CW-1:0] c, input logic [63:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = DW'(d);
  endtask

  task automatic n_beat(input logic v, input logic [CW-1:0] c, input logic [63:0] d);
    n_in_valid = v;
    n_in_ctrl  = c;
    n_in_data  = DW'(d);
  endtask

  initial begin
    reset = 1'b0;
    beat(1'b1, 15'h7FFF, 64'hDEAD);
    flush = 1'b1; out_ready = 1'b0; cnt_clr = 1'b0;
    n_beat(1'b0, '0, 64'h0);
    n_flush = 1'b0; n_out_ready = 1'b0; n_cnt_clr = 1'b0;

    // Reset held for 3 cycles, flush asserted meanwhile must be ignored.
    repeat (3) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_ctrl", out_ctrl, 0);
    check("rst_out_data", out_data[63:0], 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_stall", stall_cnt, 0);
    check("rst_squash", squash_cnt, 0);
    check("rst_ns_in_ready", n_in_ready, 0);

    // Release and first beat.
    flush = 1'b0;
    beat(1'b1, 15'h1A5, 64'h100);
    out_ready = 1'b1;
    #2 reset = 1'b1;
    check("rel_in_ready_still_0", in_ready, 0);
    tick();
    check("first_edge_in_ready", in_ready, 1);
    check("first_edge_out_valid", out_valid, 0);
    tick();
    check("first_out_valid", out_valid, 1);
    check("first_out_ctrl", out_ctrl, 15'h1A5);
    check("first_out_data", out_data[63:0], 64'h100);
    beat(1'b0, '0, 64'h0);
    tick();
    check("bubble_out_valid", out_valid, 0);
    check("bubble_out_ctrl", out_ctrl, 0);
    check("bubble_data_held", out_data[63:0], 64'h100);

    // Skid fill: A, B with downstream stalled.
    out_ready = 1'b0;
    beat(1'b1, 15'h011, 64'h10);
    tick();
    check("skid_A_out", out_data[63:0], 64'h10);
    check("skid_A_ready", in_ready, 1);
    beat(1'b1, 15'h022, 64'h20);
    tick();
    check("skid_in_ready_0", in_ready, 0);
    check("skid_out_still_A", out_data[63:0], 64'h10);
    check("skid_stall_1", stall_cnt, 1);
    beat(1'b0, '0, 64'h0);
    tick();
    check("skid_stall_2", stall_cnt, 2);
    check("skid_ready_held_0", in_ready, 0);
    out_ready = 1'b1;
    tick();
    check("skid_B_out", out_data[63:0], 64'h20);
    check("skid_B_ctrl", out_ctrl, 15'h022);
    check("skid_ready_back", in_ready, 1);
    tick();
    check("skid_drained", out_valid, 0);
    check("skid_drained_ctrl", out_ctrl, 0);
    check("skid_stall_final", stall_cnt, 2);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_stall", stall_cnt, 0);

    // Full throughput: 8 back-to-back beats.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      beat(1'b1, CW'(i + 1), 64'(i));
      tick();
      check($sformatf("tput_valid_%0d", i), out_valid, 1);
      check($sformatf("tput_data_%0d", i), out_data[63:0], 64'(i));
      check($sformatf("tput_ready_%0d", i), in_ready, 1);
    end
    beat(1'b0, '0, 64'h0);
    tick();
    check("tput_drained", out_valid, 0);
    check("tput_stall", stall_cnt, 0);

    // Flush with two entries held, incoming beat dropped.
    out_ready = 1'b0;
    beat(1'b1, 15'h044, 64'h40);
    tick();
    beat(1'b1, 15'h055, 64'h50);
    tick();
    check("fl_pre_skid", in_ready, 0);
    beat(1'b1, 15'h033, 64'h30);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    beat(1'b0, '0, 64'h0);
    check("fl_out_valid", out_valid, 0);
    check("fl_out_ctrl", out_ctrl, 0);
    check("fl_squash_2", squash_cnt, 2);
    check("fl_stall_1", stall_cnt, 1);
    check("fl_in_ready", in_ready, 1);
    out_ready = 1'b1;
    tick();
    check("fl_no_0x30_a", out_valid, 0);
    tick();
    check("fl_no_0x30_b", out_valid, 0);

    // Flush while the held beat is consumed and a new beat is offered.
    out_ready = 1'b0;
    beat(1'b1, 15'h077, 64'h70);
    tick();
    check("flc_full", out_data[63:0], 64'h70);
    out_ready = 1'b1;
    beat(1'b1, 15'h066, 64'h60);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    beat(1'b0, '0, 64'h0);
    check("flc_squash_unchanged", squash_cnt, 2);
    check("flc_out_valid", out_valid, 0);

    // Flush of a single un-consumed entry.
    out_ready = 1'b0;
    beat(1'b1, 15'h088, 64'h80);
    tick();
    beat(1'b0, '0, 64'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl1_squash_3", squash_cnt, 3);
    check("fl1_stall", stall_cnt, 1);

    // Saturation of the 4-bit stall counter.
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("sat_clr_stall", stall_cnt, 0);
    check("sat_clr_squash", squash_cnt, 0);
    beat(1'b1, 15'h099, 64'h90);
    tick();
    beat(1'b0, '0, 64'h0);
    repeat (20) tick();
    check("sat_stall_15", stall_cnt, 15);
    check("sat_data_held", out_data[63:0], 64'h90);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("sat_clr_prio", stall_cnt, 0);
    tick();
    check("sat_resume_1", stall_cnt, 1);
    tick();
    check("sat_resume_2", stall_cnt, 2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("sat_flush_squash", squash_cnt, 1);

    // Single-register variant: combinational in_ready.
    n_beat(1'b1, 15'h0A0, 64'hA0);
    n_out_ready = 1'b0;
    #1 check("ns_ready_empty", n_in_ready, 1);
    tick();
    check("ns_A_valid", n_out_valid, 1);
    check("ns_A_data", n_out_data[63:0], 64'hA0);
    n_beat(1'b1, 15'h0B0, 64'hB0);
    #1 check("ns_ready_stalled", n_in_ready, 0);
    n_out_ready = 1'b1;
    #1 check("ns_ready_comb", n_in_ready, 1);
    tick();
    check("ns_B_data", n_out_data[63:0], 64'hB0);
    check("ns_B_ctrl", n_out_ctrl, 15'h0B0);
    check("ns_stall_0", n_stall_cnt, 0);
    n_beat(1'b1, 15'h0D0, 64'hD0);
    n_out_ready = 1'b0;
    tick();
    check("ns_hold_B", n_out_data[63:0], 64'hB0);
    check("ns_no_skid_ready", n_in_ready, 0);
    check("ns_stall_1", n_stall_cnt, 1);
    n_beat(1'b0, '0, 64'h0);
    n_out_ready = 1'b1;
    tick();
    check("ns_drained", n_out_valid, 0);
    check("ns_drained_ctrl", n_out_ctrl, 0);

    // Asynchronous reset mid-stall drops the held entry immediately.
    out_ready = 1'b0;
    beat(1'b1, 15'h0EE, 64'hE0);
    tick();
    beat(1'b0, '0, 64'h0);
    #2 reset = 1'b0;
    #1 check("async_rst_valid", out_valid, 0);
    check("async_rst_ctrl", out_ctrl, 0);
    check("async_rst_ready", in_ready, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
